// File: rtl/adder_rr_scheduler.sv
// ---------------------------------------------------------------------------
// adder_rr_scheduler
//   Time-shares one external combinational 32-bit adder among NUM_REQ
//   requesters. A granted request is a WORDS*32-bit add. It is issued one
//   32-bit word per cycle, least significant word first, and the carry is
//   chained through the adder's carry-in. Grants rotate round-robin. Only
//   one request is in flight at a time: IDLE -> ADD (WORDS cycles) -> RESP.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req_valid         per-requester request pending
//   o_req_ready         one-hot accept strobe (IDLE only)
//   i_req_a, i_req_b    per-requester operands, requester i at [i*W +: W]
//   i_req_cin           per-requester carry-in
//   o_add_num1/2,cin    drive to the shared adder (zero outside ADD)
//   i_add_sum,cout      adder result, same cycle
//   o_rsp_valid/ready   result handshake
//   o_rsp_id            requester index of the result
//   o_rsp_sum/cout      W-bit sum and final carry
//   o_busy              scheduler not idle
// ---------------------------------------------------------------------------

// Per-requester slice: the rotation distance from the round-robin pointer
// (0 = highest priority) and the requester's ready strobe.
module adder_rr_lane #(
    parameter int NUM_REQ = 4,
    parameter int IDX     = 0,
    parameter int IDW     = 2
) (
    input  logic [IDW-1:0] i_ptr,
    input  logic           i_sel_en,
    input  logic [IDW-1:0] i_grant,
    output logic [IDW-1:0] o_dist,
    output logic           o_ready
);
    assign o_dist  = IDW'((IDX + NUM_REQ - int'(i_ptr)) % NUM_REQ);
    assign o_ready = i_sel_en && (i_grant == IDW'(IDX));
endmodule

module adder_rr_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int WORDS   = 2,
    localparam int IDW     = $clog2(NUM_REQ),
    localparam int W       = WORDS * 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    output logic [NUM_REQ-1:0]   o_req_ready,
    input  logic [NUM_REQ*W-1:0] i_req_a,
    input  logic [NUM_REQ*W-1:0] i_req_b,
    input  logic [NUM_REQ-1:0]   i_req_cin,
    output logic [31:0]          o_add_num1,
    output logic [31:0]          o_add_num2,
    output logic                 o_add_cin,
    input  logic [31:0]          i_add_sum,
    input  logic                 i_add_cout,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [IDW-1:0]       o_rsp_id,
    output logic [W-1:0]         o_rsp_sum,
    output logic                 o_rsp_cout,
    output logic                 o_busy
);

    localparam int WIDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_RESP} state_t;

    // Request captured at accept; later operand changes are ignored.
    typedef struct packed {
        logic [IDW-1:0]         id;
        logic [WORDS-1:0][31:0] a;
        logic [WORDS-1:0][31:0] b;
    } op_t;

    state_t                 r_state, w_state_nxt;
    op_t                    r_op;
    logic [IDW-1:0]         r_ptr;
    logic                   r_carry;
    logic [WIDXW-1:0]       r_widx;
    logic [WORDS-1:0][31:0] r_sum;
    logic                   r_cout;

    // Word-indexed views of the flat operand buses.
    logic [NUM_REQ-1:0][WORDS-1:0][31:0] w_req_a, w_req_b;
    assign w_req_a = i_req_a;
    assign w_req_b = i_req_b;

    // ------------------------------------------------------------------
    // Round-robin grant: among valid requesters pick the smallest distance
    // from the pointer; each lane reports its own distance.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0][IDW-1:0] w_dist;
    logic [IDW-1:0]              w_grant, w_best, w_ptr_nxt;
    logic                        w_found, w_sel_en;

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_best  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req_valid[i] && (!w_found || (w_dist[i] < w_best))) begin
                w_found = 1'b1;
                w_best  = w_dist[i];
                w_grant = IDW'(i);
            end
        end
    end

    assign w_sel_en  = (r_state == S_IDLE) && w_found;
    assign w_ptr_nxt = (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + IDW'(1);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        adder_rr_lane #(
            .NUM_REQ (NUM_REQ),
            .IDX     (g),
            .IDW     (IDW)
        ) u_lane (
            .i_ptr    (r_ptr),
            .i_sel_en (w_sel_en),
            .i_grant  (w_grant),
            .o_dist   (w_dist[g]),
            .o_ready  (o_req_ready[g])
        );
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic w_last;
    assign w_last = (r_widx == WIDXW'(WORDS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_add_num1  = '0;
        o_add_num2  = '0;
        o_add_cin   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_ADD;
            end
            S_ADD: begin
                o_add_num1 = r_op.a[r_widx];
                o_add_num2 = r_op.b[r_widx];
                o_add_cin  = r_carry;
                if (w_last) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (i_rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op    <= '0;
            r_ptr   <= '0;
            r_carry <= 1'b0;
            r_widx  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op.id <= w_grant;
                        r_op.a  <= w_req_a[w_grant];
                        r_op.b  <= w_req_b[w_grant];
                        r_carry <= i_req_cin[w_grant];
                        r_widx  <= '0;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                S_ADD: begin
                    r_sum[r_widx] <= i_add_sum;
                    r_carry       <= i_add_cout;
                    r_widx        <= r_widx + WIDXW'(1);
                    if (w_last) r_cout <= i_add_cout;
                end
                default: ;
            endcase
        end
    end

    assign o_rsp_valid = (r_state == S_RESP);
    assign o_busy      = (r_state != S_IDLE);
    assign o_rsp_id    = r_op.id;
    assign o_rsp_sum   = r_sum;
    assign o_rsp_cout  = r_cout;

endmodule
